// File: rtl/vic_pkg.sv
// Shared definitions for the nested vectored interrupt controller.
//   vic_state_e : controller FSM states (IDLE / DISPATCH / RETURN)
//   SEL_*       : register-select field values of i_VIC_regaddr[6:5]
// The stack entry type {pc, level} depends on the top-level ADDR_W/PRIO_W
// parameters, so it is declared inside vic_nested where those are known.
package vic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_RETURN   = 2'd2
    } vic_state_e;

    localparam logic [1:0] SEL_VEC  = 2'b00;
    localparam logic [1:0] SEL_PRIO = 2'b01;
    localparam logic [1:0] SEL_MASK = 2'b10;

endpackage

// File: rtl/vic_prio_arb.sv
// Combinational N_SRC-way maximum-priority arbiter.
// Among the eligible sources it picks the highest priority; on a tie the
// lowest index wins.
// Ports:
//   elig_i      : per-source eligibility
//   prio_i      : flattened priorities, source i at [i*PRIO_W +: PRIO_W]
//   win_valid_o : at least one eligible source
//   win_idx_o   : index of the winner (0 when none)
//   win_prio_o  : priority of the winner (0 when none)
module vic_prio_arb
    import vic_pkg::*;
#(
    parameter int N_SRC  = 31,
    parameter int PRIO_W = 3
) (
    input  logic [N_SRC-1:0]        elig_i,
    input  logic [N_SRC*PRIO_W-1:0] prio_i,
    output logic                    win_valid_o,
    output logic [4:0]              win_idx_o,
    output logic [PRIO_W-1:0]       win_prio_o
);

    // Linear scan: strict greater-than while walking upward keeps the lowest index on ties.
    always_comb begin
        logic              take_s;
        logic              best_valid_s;
        logic [4:0]        best_idx_s;
        logic [PRIO_W-1:0] best_prio_s;
        take_s       = 1'b0;
        best_valid_s = 1'b0;
        best_idx_s   = 5'd0;
        best_prio_s  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            take_s       = elig_i[i] &&
                           (!best_valid_s || (prio_i[i*PRIO_W +: PRIO_W] > best_prio_s));
            best_valid_s = best_valid_s | take_s;
            best_idx_s   = take_s ? 5'(i) : best_idx_s;
            best_prio_s  = take_s ? prio_i[i*PRIO_W +: PRIO_W] : best_prio_s;
        end
        win_valid_o = best_valid_s;
        win_idx_o   = best_idx_s;
        win_prio_o  = best_prio_s;
    end

endmodule

// File: rtl/vic_nested.sv
// Nested vectored interrupt controller.
// Edge-latches N_SRC asynchronous sources, arbitrates by programmable priority,
// and redirects the CPU PC with a one-cycle pulse. A higher-priority request
// preempts a running handler; return PC and running level are kept on an
// internal stack.
// Build option: define VIC_NESTING_EN for preemption with a stack of DEPTH
// entries. Without it the stack is one entry deep: nothing dispatches while a
// handler is active, but priority still arbitrates among pending sources.
// Ports:
//   i_clk, i_rst (async, active low)
//   i_ext         : asynchronous sources, rising-edge sensitive
//   i_PC          : resume address pushed at dispatch
//   i_iret        : return-from-interrupt pulse
//   i_VIC_we / i_VIC_regaddr {sel,idx} / i_VIC_data : config write port
//   o_VIC_iaddr   : PC redirect target (0 when no pulse)
//   o_VIC_PC_ctrl : one-cycle PC load pulse
//   o_IRQ         : a handler is active (stack non-empty)
//   o_level       : running priority level, 0 = thread mode
module vic_nested
    import vic_pkg::*;
#(
    parameter int N_SRC  = 31,
    parameter int PRIO_W = 3,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_SRC-1:0]  i_ext,
    input  logic [ADDR_W-1:0] i_PC,
    input  logic              i_iret,
    input  logic              i_VIC_we,
    input  logic [6:0]        i_VIC_regaddr,
    input  logic [ADDR_W-1:0] i_VIC_data,
    output logic [ADDR_W-1:0] o_VIC_iaddr,
    output logic              o_VIC_PC_ctrl,
    output logic              o_IRQ,
    output logic [PRIO_W-1:0] o_level
);

`ifdef VIC_NESTING_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
    localparam int unused_depth = DEPTH;
`endif
    localparam int SP_W  = $clog2(EFF_DEPTH + 1);
    localparam int IDX_W = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
    localparam int STK_N = 1 << IDX_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [PRIO_W-1:0] level;
    } stack_entry_t;

    logic [N_SRC-1:0]        sync1_q, sync2_q, prev_q;
    logic [N_SRC-1:0]        edge_s, clr_s, elig_s;
    logic [N_SRC-1:0]        pending_q, pending_d;
    logic [N_SRC-1:0]        mask_q;
    logic [ADDR_W-1:0]       vector_q [N_SRC];
    logic [PRIO_W-1:0]       prio_q   [N_SRC];
    logic [N_SRC*PRIO_W-1:0] prio_flat_s;
    stack_entry_t            stack_q  [STK_N];
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [IDX_W-1:0]        top_idx_s, push_idx_s;
    logic                    full_s, push_s;
    vic_state_e              state_q, state_d;
    logic [4:0]              win_idx_q, win_idx_d, win_idx_s;
    logic [PRIO_W-1:0]       win_prio_q, win_prio_d, win_prio_s;
    logic                    win_valid_s;
    logic [PRIO_W-1:0]       level_q, level_d;
    logic [ADDR_W-1:0]       vec_sel_s;
    logic [1:0]              cfg_sel_s;
    logic [4:0]              cfg_idx_s;

    assign cfg_sel_s  = i_VIC_regaddr[6:5];
    assign cfg_idx_s  = i_VIC_regaddr[4:0];
    assign full_s     = (sp_q == SP_W'(EFF_DEPTH));
    assign top_idx_s  = IDX_W'(sp_q - SP_W'(1));
    assign push_idx_s = IDX_W'(sp_q);
    assign edge_s     = sync2_q & ~prev_q;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= i_ext;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Configuration registers; out-of-range indices and the unused select are ignored.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mask_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                vector_q[i] <= '0;
                prio_q[i]   <= '0;
            end
        end else if (i_VIC_we) begin
            if (cfg_sel_s == SEL_MASK) begin
                mask_q <= i_VIC_data[N_SRC-1:0];
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (cfg_idx_s == 5'(i)) begin
                    if (cfg_sel_s == SEL_VEC) begin
                        vector_q[i] <= i_VIC_data;
                    end
                    if (cfg_sel_s == SEL_PRIO) begin
                        prio_q[i] <= i_VIC_data[PRIO_W-1:0];
                    end
                end
            end
        end
    end

    // Eligibility, flattened priorities, dispatch-clear decode and vector mux.
    always_comb begin
        elig_s      = '0;
        prio_flat_s = '0;
        clr_s       = '0;
        vec_sel_s   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            prio_flat_s[i*PRIO_W +: PRIO_W] = prio_q[i];
            elig_s[i] = pending_q[i] & mask_q[i] & (prio_q[i] != '0) &
                        (prio_q[i] > level_q) & ~full_s;
            clr_s[i]  = (state_q == ST_DISPATCH) && (win_idx_q == 5'(i));
            vec_sel_s = (win_idx_q == 5'(i)) ? vector_q[i] : vec_sel_s;
        end
        // A new edge in the clearing cycle keeps the request pending.
        pending_d = (pending_q & ~clr_s) | edge_s;
    end

    vic_prio_arb #(
        .N_SRC  (N_SRC),
        .PRIO_W (PRIO_W)
    ) u_arb (
        .elig_i      (elig_s),
        .prio_i      (prio_flat_s),
        .win_valid_o (win_valid_s),
        .win_idx_o   (win_idx_s),
        .win_prio_o  (win_prio_s)
    );

    // FSM next state; a return request in IDLE takes precedence over a dispatch.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        level_d    = level_q;
        win_idx_d  = win_idx_q;
        win_prio_d = win_prio_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_iret && (sp_q != '0)) begin
                    state_d = ST_RETURN;
                end else if (win_valid_s) begin
                    state_d    = ST_DISPATCH;
                    win_idx_d  = win_idx_s;
                    win_prio_d = win_prio_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                push_s  = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                level_d = win_prio_q;
                state_d = ST_IDLE;
            end
            ST_RETURN: begin
                sp_d    = sp_q - SP_W'(1);
                level_d = stack_q[top_idx_s].level;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pending, stack pointer, level and latched winner registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            sp_q       <= '0;
            level_q    <= '0;
            win_idx_q  <= 5'd0;
            win_prio_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            sp_q       <= sp_d;
            level_q    <= level_d;
            win_idx_q  <= win_idx_d;
            win_prio_q <= win_prio_d;
        end
    end

    // Return stack: the resume PC and the interrupted level are pushed in DISPATCH.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < STK_N; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_s) begin
            stack_q[push_idx_s] <= '{pc: i_PC, level: level_q};
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        o_VIC_PC_ctrl = (state_q != ST_IDLE);
        o_IRQ         = (sp_q != '0);
        o_level       = level_q;
        case (state_q)
            ST_DISPATCH: o_VIC_iaddr = vec_sel_s;
            ST_RETURN:   o_VIC_iaddr = stack_q[top_idx_s].pc;
            default:     o_VIC_iaddr = '0;
        endcase
    end

endmodule
